// File: rtl/mux_arb_pkg.sv
// Shared types and sizing helpers for the ALU operand-mux round-robin arbiter.
package mux_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam int DEF_MAX_HOLD = 4;

  // Width of a counter that must reach max_hold.
  function automatic int cnt_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] idx
);

  logic [SEL_WIDTH-1:0] cand;

  // Scan from the far end back toward ptr so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_WIDTH'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 4:1 ALU operand mux, with a bounded burst
// of accepted beats per grant and back-to-back re-grant on release.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2,
  parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic                 mux_ready,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 busy
);

  localparam int              CW   = cnt_w(MAX_HOLD);
  localparam logic [CW-1:0]   LAST = CW'(MAX_HOLD - 1);

  arb_state_e           state;
  logic [SEL_WIDTH-1:0] owner, ptr, nxt_ptr;
  logic [CW-1:0]        cnt;
  logic                 owner_req, beat, rel;
  logic                 idle_found, re_found;
  logic [SEL_WIDTH-1:0] idle_idx, re_idx;

  assign owner_req = req[owner];
  assign beat      = (state == GRANT) && owner_req && mux_ready;
  // A dropped request never counts as a beat, so both causes fold into one release.
  assign rel       = (state == GRANT) && (!owner_req || (beat && cnt == LAST));
  assign nxt_ptr   = owner + SEL_WIDTH'(1);
  assign sel       = owner;

  rr_pick #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_WIDTH)) u_idle_pick (
    .req   (req),
    .ptr   (ptr),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Starting at owner+1 leaves the old owner eligible but last in line;
  // a dropped owner's bit is already 0 in req.
  rr_pick #(.NUM_REQ(NUM_REQ), .SEL_WIDTH(SEL_WIDTH)) u_re_pick (
    .req   (req),
    .ptr   (nxt_ptr),
    .found (re_found),
    .idx   (re_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt <= '0;
          if (idle_found) begin
            owner <= idle_idx;
            gnt   <= NUM_REQ'(1) << idle_idx;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= nxt_ptr;
            cnt <= '0;
            if (re_found) begin
              owner <= re_idx;
              gnt   <= NUM_REQ'(1) << re_idx;
            end else begin
              gnt   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (beat) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
